// File: rtl/spawn_scheduler_pkg.sv
// Shared types and helpers for the obstacle spawn scheduler.
// State encoding, LFSR feedback and the saturation/fallback constants.
package spawn_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCROLL = 2'd1,
    ST_DRAW   = 2'd2,
    ST_OFFER  = 2'd3
  } state_t;

  localparam logic [2:0] SEED_FALLBACK = 3'b001;
  localparam logic [7:0] DROP_MAX      = 8'hFF;

  // Maximal-length 3-bit sequence: 001,010,101,011,111,110,100,001
  function automatic logic [2:0] lfsr_next(input logic [2:0] v);
    return {v[1], v[0], v[2] ^ v[1]};
  endfunction

endpackage

// File: rtl/spawn_scheduler_lfsr3.sv
// 3-bit maximal-length LFSR; loads the seed while rst is high and steps on adv.
// A zero seed is replaced by the fallback so the register never locks up.
module lfsr3
  import spawn_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] seed,
  input  logic       adv,
  output logic [2:0] value
);

  logic [2:0] seed_safe;

  assign seed_safe = (seed == 3'b000) ? SEED_FALLBACK : seed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= seed_safe;
    end else if (adv) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/spawn_scheduler.sv
// Scroll position counter plus LFSR-driven lane picker offering spawns over valid/ready.
// Scrolling never stalls; wraps arriving while a spawn is in flight are queued once, then dropped.
module spawn_scheduler
  import spawn_scheduler_pkg::*;
#(
  parameter int NUM_LANES = 5,
  parameter int MAX_RETRY = 3,
  parameter int POS_W     = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 tick,
  input  logic [POS_W-1:0]     limit,
  input  logic [2:0]           seed,
  input  logic [NUM_LANES-1:0] lane_busy,
  input  logic                 spawn_ready,
  output logic [POS_W-1:0]     position,
  output logic                 spawn_valid,
  output logic [2:0]           spawn_lane,
  output logic [7:0]           drop_cnt,
  output logic                 running
);

  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  state_t state, state_nxt;

  logic [2:0]         lfsr;
  logic [2:0]         cand;
  logic [7:0]         busy_ext;
  logic               cand_bad;
  logic               pending;
  logic [RETRY_W-1:0] retry;

  logic step;
  logic wrap;
  logic in_flight;
  logic take;
  logic retry_draw;
  logic draw_drop;
  logic xfer;
  logic exit_flight;
  logic redraw;
  logic wrap_drop;
  logic lfsr_adv;

  lfsr3 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .seed  (seed),
    .adv   (lfsr_adv),
    .value (lfsr)
  );

  // Lanes beyond NUM_LANES read as permanently busy, so one lookup covers both invalid cases.
  assign cand     = lfsr - 3'd1;
  assign busy_ext = {{(8 - NUM_LANES){1'b1}}, lane_busy};
  assign cand_bad = busy_ext[cand];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (start) state_nxt = ST_SCROLL;
        ST_SCROLL: if (wrap) state_nxt = ST_DRAW;
        ST_DRAW: begin
          if (take) begin
            state_nxt = ST_OFFER;
          end else if (draw_drop) begin
            state_nxt = redraw ? ST_DRAW : ST_SCROLL;
          end
        end
        ST_OFFER:  if (xfer) state_nxt = redraw ? ST_DRAW : ST_SCROLL;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    running     = (state != ST_IDLE);
    step        = running && !stop && tick;
    wrap        = step && (position >= limit);
    in_flight   = (state == ST_DRAW) || (state == ST_OFFER);
    take        = (state == ST_DRAW) && !stop && !cand_bad;
    retry_draw  = (state == ST_DRAW) && !stop && cand_bad && (retry < RETRY_MAX);
    draw_drop   = (state == ST_DRAW) && !stop && cand_bad && !(retry < RETRY_MAX);
    xfer        = (state == ST_OFFER) && !stop && spawn_valid && spawn_ready;
    exit_flight = draw_drop || xfer;
    // Leaving DRAW/OFFER with a queued or coincident wrap goes straight back to DRAW.
    redraw      = exit_flight && (pending || wrap);
    wrap_drop   = in_flight && wrap && pending && !exit_flight;
    lfsr_adv    = wrap || retry_draw;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      position    <= '0;
      spawn_valid <= 1'b0;
      spawn_lane  <= 3'd0;
      drop_cnt    <= 8'd0;
      pending     <= 1'b0;
      retry       <= '0;
    end else if (stop) begin
      spawn_valid <= 1'b0;
      pending     <= 1'b0;
      retry       <= '0;
    end else begin
      if (step) begin
        position <= wrap ? '0 : position + POS_W'(1);
      end

      if (take) begin
        spawn_valid <= 1'b1;
        spawn_lane  <= cand;
      end else if (xfer) begin
        spawn_valid <= 1'b0;
      end

      if (((state == ST_SCROLL) && wrap) || exit_flight) begin
        retry <= '0;
      end else if (retry_draw) begin
        retry <= retry + RETRY_W'(1);
      end

      // A wrap coinciding with the exit is either consumed as the redraw or re-queued.
      if (exit_flight) begin
        pending <= pending && wrap;
      end else if (in_flight && wrap) begin
        pending <= 1'b1;
      end

      if ((draw_drop || wrap_drop) && (drop_cnt != DROP_MAX)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_spawn_scheduler.sv
// Directed bench for spawn_scheduler with hand-traced expected values.
// Time origin for each scenario: cycle 0 is the edge that samples start.
module tb_spawn_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       tick = 1'b0;
  logic [9:0] limit = 10'd3;
  logic [2:0] seed = 3'b001;
  logic [4:0] lane_busy = 5'd0;
  logic       spawn_ready = 1'b0;
  logic [9:0] position;
  logic       spawn_valid;
  logic [2:0] spawn_lane;
  logic [7:0] drop_cnt;
  logic       running;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spawn_scheduler #(.NUM_LANES(5), .MAX_RETRY(3), .POS_W(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .tick        (tick),
    .limit       (limit),
    .seed        (seed),
    .lane_busy   (lane_busy),
    .spawn_ready (spawn_ready),
    .position    (position),
    .spawn_valid (spawn_valid),
    .spawn_lane  (spawn_lane),
    .drop_cnt    (drop_cnt),
    .running     (running)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [2:0] s);
    rst = 1'b1; seed = s; start = 1'b0; stop = 1'b0; tick = 1'b0;
    limit = 10'd3; lane_busy = 5'd0; spawn_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(3'b101);
    checks++; if (position !== 10'd0) begin errors++; $display("FAIL reset_pos got=%0d exp=0", position); end
    checks++; if (spawn_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", spawn_valid); end
    checks++; if (spawn_lane !== 3'd0) begin errors++; $display("FAIL reset_lane got=%0d exp=0", spawn_lane); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b exp=0", running); end
  endtask

  // Lanes 1,4,2 on the first three wraps; the fourth retries twice and offers lane 3.
  task automatic test_spawn_sequence();
    logic       ev;
    logic [2:0] el;
    do_reset(3'b001);
    spawn_ready = 1'b1; tick = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (position !== 10'd0) begin errors++; $display("FAIL seq_start_pos got=%0d exp=0", position); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL seq_running got=%b exp=1", running); end
    for (int k = 1; k <= 19; k++) begin
      step();
      ev = 1'b0; el = 3'd0;
      case (k)
        5:  begin ev = 1'b1; el = 3'd1; end
        9:  begin ev = 1'b1; el = 3'd4; end
        13: begin ev = 1'b1; el = 3'd2; end
        19: begin ev = 1'b1; el = 3'd3; end
        default: ;
      endcase
      checks++;
      if (position !== 10'(k % 4)) begin errors++; $display("FAIL seq_pos cyc=%0d got=%0d exp=%0d", k, position, k % 4); end
      checks++;
      if (spawn_valid !== ev) begin errors++; $display("FAIL seq_valid cyc=%0d got=%b exp=%b", k, spawn_valid, ev); end
      if (ev) begin
        checks++;
        if (spawn_lane !== el) begin errors++; $display("FAIL seq_lane cyc=%0d got=%0d exp=%0d", k, spawn_lane, el); end
      end
    end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL seq_drop got=%0d exp=0", drop_cnt); end
  endtask

  // Every lane busy: one drop per wrap, first at cycle 8, saturating at 255 on cycle 1024.
  task automatic test_all_busy();
    logic seen;
    seen = 1'b0;
    do_reset(3'b001);
    lane_busy = 5'b11111; spawn_ready = 1'b1; tick = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 1100; k++) begin
      step();
      if (spawn_valid) seen = 1'b1;
      if (k == 7) begin
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL busy_drop7 got=%0d exp=0", drop_cnt); end
      end
      if (k == 8) begin
        checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL busy_drop8 got=%0d exp=1", drop_cnt); end
      end
      if (k == 12) begin
        checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL busy_drop12 got=%0d exp=2", drop_cnt); end
      end
      if (k == 1023) begin
        checks++; if (drop_cnt !== 8'd254) begin errors++; $display("FAIL busy_drop1023 got=%0d exp=254", drop_cnt); end
      end
      if (k == 1024) begin
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL busy_drop1024 got=%0d exp=255", drop_cnt); end
      end
    end
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL busy_sat got=%0d exp=255", drop_cnt); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL busy_no_valid got=%b exp=0", seen); end
  endtask

  // Renderer stalls 12 cycles: wraps at 8/12/16 queue one and drop two; release leads to redraw.
  task automatic test_backpressure();
    do_reset(3'b001);
    tick = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k >= 5 && k <= 16) begin
        checks++;
        if (spawn_valid !== 1'b1 || spawn_lane !== 3'd1) begin
          errors++; $display("FAIL bp_hold cyc=%0d got=%b/%0d exp=1/1", k, spawn_valid, spawn_lane);
        end
      end
      if (k == 11) begin
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL bp_drop11 got=%0d exp=0", drop_cnt); end
      end
      if (k == 12) begin
        checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL bp_drop12 got=%0d exp=1", drop_cnt); end
      end
      if (k == 16) begin
        checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL bp_drop16 got=%0d exp=2", drop_cnt); end
        spawn_ready = 1'b1;
      end
      if (k == 17 || k == 18 || k == 19) begin
        checks++; if (spawn_valid !== 1'b0) begin errors++; $display("FAIL bp_after cyc=%0d got=%b exp=0", k, spawn_valid); end
      end
      if (k == 20) begin
        checks++;
        if (spawn_valid !== 1'b1 || spawn_lane !== 3'd3) begin
          errors++; $display("FAIL bp_redraw got=%b/%0d exp=1/3", spawn_valid, spawn_lane);
        end
        checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL bp_drop20 got=%0d exp=2", drop_cnt); end
      end
    end
  endtask

  task automatic test_stop_resume();
    do_reset(3'b001);
    tick = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 5; k++) step();
    checks++; if (spawn_valid !== 1'b1) begin errors++; $display("FAIL stop_pre_valid got=%b exp=1", spawn_valid); end
    stop = 1'b1;
    step();
    checks++; if (spawn_valid !== 1'b0) begin errors++; $display("FAIL stop_valid got=%b exp=0", spawn_valid); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL stop_running got=%b exp=0", running); end
    checks++; if (position !== 10'd1) begin errors++; $display("FAIL stop_pos got=%0d exp=1", position); end
    start = 1'b1;
    step();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL stop_wins got=%b exp=0", running); end
    start = 1'b0; stop = 1'b0;
    step();
    checks++; if (position !== 10'd1) begin errors++; $display("FAIL stop_frozen got=%0d exp=1", position); end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (running !== 1'b1 || position !== 10'd1) begin
      errors++; $display("FAIL resume got=%b/%0d exp=1/1", running, position);
    end
    step();
    checks++; if (position !== 10'd2) begin errors++; $display("FAIL resume_pos got=%0d exp=2", position); end
    step();
    step();
    checks++; if (position !== 10'd0) begin errors++; $display("FAIL resume_wrap got=%0d exp=0", position); end
    step();
    checks++;
    if (spawn_valid !== 1'b1 || spawn_lane !== 3'd4) begin
      errors++; $display("FAIL resume_lane got=%b/%0d exp=1/4", spawn_valid, spawn_lane);
    end
  endtask

  // limit==0: every tick wraps; a wrap during OFFER exit redraws and the next one drops.
  task automatic test_limit_zero();
    do_reset(3'b001);
    limit = 10'd0; spawn_ready = 1'b1; tick = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++; if (position !== 10'd0) begin errors++; $display("FAIL lz_pos cyc=%0d got=%0d exp=0", k, position); end
      if (k == 2) begin
        checks++;
        if (spawn_valid !== 1'b1 || spawn_lane !== 3'd1) begin
          errors++; $display("FAIL lz_lane1 got=%b/%0d exp=1/1", spawn_valid, spawn_lane);
        end
      end
      if (k == 3) begin
        checks++; if (spawn_valid !== 1'b0) begin errors++; $display("FAIL lz_xfer got=%b exp=0", spawn_valid); end
      end
      if (k == 4) begin
        checks++;
        if (spawn_valid !== 1'b1 || spawn_lane !== 3'd2) begin
          errors++; $display("FAIL lz_lane2 got=%b/%0d exp=1/2", spawn_valid, spawn_lane);
        end
        checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL lz_drop got=%0d exp=1", drop_cnt); end
      end
    end
  endtask

  task automatic test_seed_zero_async_reset();
    do_reset(3'b000);
    tick = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 5; k++) step();
    checks++;
    if (spawn_valid !== 1'b1 || spawn_lane !== 3'd1) begin
      errors++; $display("FAIL seed0_lane got=%b/%0d exp=1/1", spawn_valid, spawn_lane);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (spawn_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b exp=0", spawn_valid); end
    checks++; if (position !== 10'd0) begin errors++; $display("FAIL arst_pos got=%0d exp=0", position); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL arst_running got=%b exp=0", running); end
    step();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_spawn_sequence();
    test_all_busy();
    test_backpressure();
    test_stop_resume();
    test_limit_zero();
    test_seed_zero_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
